// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - de-interleaves a 4-slot TDM stream into registered frames
// Slot 0 is marked by a sync strobe; a finished frame is held until consumed.
module tdm_demux4 #(
   parameter int WIDTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_sync,
   input  logic [WIDTH-1:0]   in_data,
   output logic [4*WIDTH-1:0] out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               locked,
   output logic [1:0]         slot,
   output logic               sync_err,
   output logic               overrun
);

   typedef enum logic {HUNT, LOCK} state_t;

   state_t               state_q, state_d;
   logic [1:0]           slot_q, slot_d;
   logic [WIDTH-1:0]     ch0_q, ch0_d, ch1_q, ch1_d, ch2_q, ch2_d;
   logic [4*WIDTH-1:0]   out_data_q, out_data_d;
   logic                 out_valid_q, out_valid_d;
   logic                 sync_err_q, sync_err_d;
   logic                 overrun_q, overrun_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= HUNT;
         slot_q      <= 2'd0;
         ch0_q       <= '0;
         ch1_q       <= '0;
         ch2_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         ch0_q       <= ch0_d;
         ch1_q       <= ch1_d;
         ch2_q       <= ch2_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
         overrun_q   <= overrun_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      ch0_d       = ch0_q;
      ch1_d       = ch1_q;
      ch2_d       = ch2_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q & ~out_ready;
      sync_err_d  = 1'b0;
      overrun_d   = 1'b0;
      if (in_valid) begin
         if (state_q == HUNT) begin
            if (in_sync) begin
               ch0_d   = in_data;
               slot_d  = 2'd1;
               state_d = LOCK;
            end
         end else if (in_sync && (slot_q != 2'd0)) begin
            // Misplaced sync: drop the partial frame and realign on this beat.
            sync_err_d = 1'b1;
            ch0_d      = in_data;
            slot_d     = 2'd1;
         end else begin
            slot_d = slot_q + 2'd1;
            case (slot_q)
               2'd0:    ch0_d = in_data;
               2'd1:    ch1_d = in_data;
               2'd2:    ch2_d = in_data;
               default: begin
                  if (!out_valid_q || out_ready) begin
                     out_data_d  = {in_data, ch2_q, ch1_q, ch0_q};
                     out_valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign locked    = (state_q == LOCK);
   assign slot      = slot_q;
   assign sync_err  = sync_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - self-checking bench for tdm_demux4
// Frame-level model checked every cycle, plus literal checks of directed scenarios.
module tb_tdm_demux4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_sync = 1'b0;
   logic [3:0]  in_data = 4'h0;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic        locked;
   logic [1:0]  slot;
   logic        sync_err;
   logic        overrun;

   int tests = 0;
   int fails = 0;
   int ovr_count = 0;
   int serr_count = 0;

   tdm_demux4 #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_sync(in_sync),
      .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .locked(locked), .slot(slot),
      .sync_err(sync_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Behavioural model: channel array, integer slot position, held frame.
   logic [3:0]  m_ch [4];
   int          m_slot = 0;
   bit          m_locked = 0;
   logic [15:0] m_out = 16'h0;
   bit          m_vld = 0;
   bit          m_serr = 0;
   bit          m_ovr = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) m_ch[i] = 4'h0;
         m_slot = 0; m_locked = 0; m_out = 16'h0;
         m_vld = 0; m_serr = 0; m_ovr = 0;
      end else begin
         bit was_vld;
         was_vld = m_vld;
         m_serr = 0;
         m_ovr  = 0;
         if (m_vld && out_ready) m_vld = 0;
         if (in_valid) begin
            if (!m_locked) begin
               if (in_sync) begin
                  m_ch[0] = in_data; m_slot = 1; m_locked = 1;
               end
            end else if (in_sync && m_slot != 0) begin
               m_serr = 1; m_ch[0] = in_data; m_slot = 1;
            end else begin
               m_ch[m_slot] = in_data;
               if (m_slot == 3) begin
                  if (!was_vld || out_ready) begin
                     m_out = {m_ch[3], m_ch[2], m_ch[1], m_ch[0]};
                     m_vld = 1;
                  end else begin
                     m_ovr = 1;
                  end
               end
               m_slot = (m_slot + 1) % 4;
            end
         end
      end
   end

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("out_data",  out_data, m_out);
      chk("out_valid", {15'b0, out_valid}, {15'b0, m_vld});
      chk("locked",    {15'b0, locked}, {15'b0, m_locked});
      chk("slot",      {14'b0, slot}, 16'(m_slot));
      chk("sync_err",  {15'b0, sync_err}, {15'b0, m_serr});
      chk("overrun",   {15'b0, overrun}, {15'b0, m_ovr});
      chk("err_excl",  {15'b0, sync_err & overrun}, 16'h0);
      if (overrun === 1'b1) ovr_count++;
      if (sync_err === 1'b1) serr_count++;
   end

   task automatic beat(input logic s, input logic [3:0] d);
      in_valid = 1'b1; in_sync = s; in_data = d;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sync = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic reset_pulse();
      rst = 1'b1; #2;
      chk("rst_out_data", out_data, 16'h0);
      chk("rst_flags", {10'b0, out_valid, locked, slot, sync_err, overrun}, 16'h0);
      idle(2);
      rst = 1'b0;
      idle(1);
   endtask

   initial begin
      // Test 1: basic frame after reset
      #2;
      chk("t1_reset_out", out_data, 16'h0);
      chk("t1_reset_flags", {10'b0, out_valid, locked, slot, sync_err, overrun}, 16'h0);
      @(posedge clk); #1; rst = 1'b0;
      idle(1);
      out_ready = 1'b1;
      beat(1'b1, 4'hE);
      chk("t1_locked", {15'b0, locked}, 16'h1);
      chk("t1_slot1", {14'b0, slot}, 16'h1);
      beat(1'b0, 4'h2); beat(1'b0, 4'h7); beat(1'b0, 4'h8);
      chk("t1_frame", out_data, 16'h872E);
      chk("t1_valid", {15'b0, out_valid}, 16'h1);
      chk("t1_slot0", {14'b0, slot}, 16'h0);
      idle(1);
      chk("t1_consumed", {15'b0, out_valid}, 16'h0);

      // Test 2: beats before sync are ignored in HUNT
      reset_pulse();
      beat(1'b0, 4'h5); beat(1'b0, 4'h6);
      chk("t2_hunt_locked", {15'b0, locked}, 16'h0);
      chk("t2_hunt_slot", {14'b0, slot}, 16'h0);
      beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h3); beat(1'b0, 4'h4);
      chk("t2_frame", out_data, 16'h4321);
      idle(1);

      // Test 3: misplaced sync realigns
      ovr_count = 0; serr_count = 0;
      beat(1'b1, 4'hA); beat(1'b0, 4'hB); beat(1'b1, 4'hC);
      chk("t3_sync_err", {15'b0, sync_err}, 16'h1);
      chk("t3_no_frame", {15'b0, out_valid}, 16'h0);
      beat(1'b0, 4'hD);
      chk("t3_err_pulse", {15'b0, sync_err}, 16'h0);
      beat(1'b0, 4'hE); beat(1'b0, 4'hF);
      chk("t3_frame", out_data, 16'hFEDC);
      idle(1);
      chk("t3_serr_count", 16'(serr_count), 16'h1);
      chk("t3_no_overrun", 16'(ovr_count), 16'h0);

      // Test 4: overrun while output held
      out_ready = 1'b0;
      beat(1'b1, 4'h1); beat(1'b0, 4'h2); beat(1'b0, 4'h3); beat(1'b0, 4'h4);
      chk("t4_frame1", out_data, 16'h4321);
      beat(1'b1, 4'h5); beat(1'b0, 4'h6); beat(1'b0, 4'h7); beat(1'b0, 4'h8);
      chk("t4_overrun", {15'b0, overrun}, 16'h1);
      chk("t4_held", out_data, 16'h4321);
      chk("t4_valid_held", {15'b0, out_valid}, 16'h1);
      chk("t4_slot", {14'b0, slot}, 16'h0);
      idle(1);
      chk("t4_ovr_pulse", {15'b0, overrun}, 16'h0);
      out_ready = 1'b1;
      idle(1);
      chk("t4_drained", {15'b0, out_valid}, 16'h0);
      chk("t4_data_kept", out_data, 16'h4321);

      // Test 5: gaps with stray in_sync while in_valid=0
      begin
         logic [3:0] vals [4];
         vals[0] = 4'h9; vals[1] = 4'h8; vals[2] = 4'h7; vals[3] = 4'h6;
         for (int i = 0; i < 4; i++) begin
            beat(i == 0, vals[i]);
            if (i < 3) begin
               in_sync = 1'b1;
               idle(3);
               chk("t5_gap_slot", {14'b0, slot}, 16'(i + 1));
               in_sync = 1'b0;
            end
         end
      end
      chk("t5_frame", out_data, 16'h6789);
      chk("t5_valid", {15'b0, out_valid}, 16'h1);
      idle(1);

      // Test 6: reset mid-frame
      beat(1'b1, 4'h1); beat(1'b0, 4'h2);
      reset_pulse();
      chk("t6_unlocked", {15'b0, locked}, 16'h0);
      for (int i = 0; i < 4; i++) beat(i == 0, 4'h3);
      chk("t6_frame", out_data, 16'h3333);
      chk("t6_valid", {15'b0, out_valid}, 16'h1);
      idle(2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
